// File: rtl/layer1_pool.sv
// Layer-1 ReLU + 2x2/stride-2 max pooling for two conv channels over an IMG_W x IMG_W frame.
// Emits one kernel-0 then one kernel-1 write per pooled pixel, and pulses o_done at frame end.
module layer1_pool #(
  parameter int DATA_W = 20,
  parameter int IMG_W  = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_valid,
  input  logic signed [DATA_W-1:0]   i_data_0,
  input  logic signed [DATA_W-1:0]   i_data_1,
  output logic                       o_wr,
  output logic                       o_sel,
  output logic [2*$clog2(IMG_W)-3:0] o_addr,
  output logic [DATA_W-1:0]          o_data,
  output logic                       o_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int HW = CW - 1;

  typedef enum logic [1:0] {IDLE, ACC, FLUSH, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]     row, col;
  logic [HW-1:0]     half_col;
  logic              accept, last_px, pool_ev;
  logic [DATA_W-1:0] relu0_p0, relu1_p0;
  logic [DATA_W-1:0] hold0, hold1;
  logic [DATA_W-1:0] lb0 [IMG_W/2];
  logic [DATA_W-1:0] lb1 [IMG_W/2];
  logic [DATA_W-1:0] pool0_p0, pool1_p0;
  logic [DATA_W-1:0] pend_data_p1;
  logic              pend_vld_p1;

  function automatic logic [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
    return x[DATA_W-1] ? '0 : $unsigned(x);
  endfunction

  // Operands are post-ReLU, so a plain unsigned compare is exact.
  function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Stage p0: ReLU and pooling on the accepted pixel
  assign accept   = i_valid && ((state == IDLE) || (state == ACC));
  assign last_px  = (&row) && (&col);
  assign pool_ev  = accept && row[0] && col[0];
  assign half_col = col[CW-1:1];
  assign relu0_p0 = relu(i_data_0);
  assign relu1_p0 = relu(i_data_1);
  assign pool0_p0 = max2(max2(lb0[half_col], hold0), relu0_p0);
  assign pool1_p0 = max2(max2(lb1[half_col], hold1), relu1_p0);

  // Line buffer carries the even-row pair maxima down to the odd row; never read before written.
  always_ff @(posedge clk) begin
    if (accept && !row[0] && col[0]) begin
      lb0[half_col] <= max2(hold0, relu0_p0);
      lb1[half_col] <= max2(hold1, relu1_p0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FLUSH waits for the pending kernel-1 write to leave before signalling DONE.
  always_comb begin
    state_nxt = state;
    o_done    = 1'b0;
    case (state)
      IDLE, ACC: begin
        if (accept) state_nxt = last_px ? FLUSH : ACC;
      end
      FLUSH: begin
        if (!pend_vld_p1) state_nxt = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: registered writes; kernel-1 result parks one cycle in the pending slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row          <= '0;
      col          <= '0;
      hold0        <= '0;
      hold1        <= '0;
      o_wr         <= 1'b0;
      o_sel        <= 1'b0;
      o_addr       <= '0;
      o_data       <= '0;
      pend_vld_p1  <= 1'b0;
      pend_data_p1 <= '0;
    end else begin
      o_wr <= 1'b0;
      if (accept) begin
        col <= col + 1'b1;
        if (&col) row <= row + 1'b1;
        if (!col[0]) begin
          hold0 <= relu0_p0;
          hold1 <= relu1_p0;
        end
      end
      // Pool events are two accepted pixels apart, so the pending slot is always free here.
      if (pool_ev) begin
        o_wr         <= 1'b1;
        o_sel        <= 1'b0;
        o_addr       <= {row[CW-1:1], half_col};
        o_data       <= pool0_p0;
        pend_vld_p1  <= 1'b1;
        pend_data_p1 <= pool1_p0;
      end else if (pend_vld_p1) begin
        o_wr        <= 1'b1;
        o_sel       <= 1'b1;
        o_data      <= pend_data_p1;
        pend_vld_p1 <= 1'b0;
      end
    end
  end

endmodule

// File: doc/layer1_pool.md
LAYER1_POOL -- requirements
Module: layer1_pool

Interface
REQ-001 SHALL have parameter DATA_W, default 20, meaning the conv-result word width (signed two's complement).
REQ-002 SHALL have parameter IMG_W, default 64, meaning the input image side in pixels; it shall be a power of two of at least 4.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port i_valid, input, 1: the conv pixel pair on i_data_0/i_data_1 is present this cycle.
REQ-006 SHALL have port i_data_0, input, DATA_W, kernel-0 conv result (signed).
REQ-007 SHALL have port i_data_1, input, DATA_W, kernel-1 conv result (signed).
REQ-008 SHALL have port o_wr, output, 1, the write strobe for the pooled-result memory.
REQ-009 SHALL have port o_sel, output, 1, the target channel memory (0 = kernel 0, 1 = kernel 1).
REQ-010 SHALL have port o_addr, output, 2*log2(IMG_W)-2, the pooled-pixel address {prow, pcol}.
REQ-011 SHALL have port o_data, output, DATA_W, the pooled value.
REQ-012 SHALL have port o_done, output, 1, a one-cycle pulse when the frame's last pooled write completes.

Function
REQ-013 SHALL treat valid input pixels as arriving in raster order (row-major, IMG_W x IMG_W); pixel position comes only from internal row/col counters advanced on i_valid; gaps of any length are allowed.
REQ-014 SHALL apply ReLU per channel on input: negative (MSB=1) -> 0, else unchanged.
REQ-015 SHALL perform 2x2 max pooling, stride 2, per channel, on ReLU values; comparisons are unsigned on non-negative values.
REQ-016 SHALL hold a line buffer of IMG_W/2 entries per channel; on an even row at an odd col, store max(held even-col value, current) at entry col>>1.
REQ-017 SHALL, on an odd row at an even col, hold the ReLU value; at an odd col, compute max(buffer[col>>1], held, current) for each channel.
REQ-018 SHALL issue the kernel-0 write in the cycle after the odd-row/odd-col pixel is accepted: o_wr=1, o_sel=0, o_addr={row>>1,col>>1}, o_data = pooled ch0.
REQ-019 SHALL issue the kernel-1 write, with the same address, in the following cycle from a one-entry pending register (o_sel=1); writes are never dropped or reordered.
REQ-020 SHALL, at back-to-back maximum input rate, interleave pending writes without collision: pool events are at least 2 valid cycles apart.
REQ-021 SHALL run the FSM IDLE -> ACC (first i_valid) -> ACC ... -> FLUSH (last pixel of frame accepted) -> DONE (one cycle, o_done=1) -> IDLE.
REQ-022 SHALL leave outputs in IDLE unchanged while i_valid=0; o_wr=0 in every cycle without a write.
REQ-023 SHALL wrap the row/col counters to 0 after pixel (IMG_W-1, IMG_W-1) and accept a new frame starting the cycle after DONE.
REQ-024 SHALL ignore i_valid in the DONE cycle (no handshake; the upstream frame gap guarantees none arrives).
REQ-025 SHALL let o_addr and o_data hold their last value when o_wr=0.

Reset
REQ-026 SHALL, on reset asserted at any time (including mid-frame), immediately set o_wr=0, o_sel=0, o_addr=0, o_data=0, o_done=0, the FSM to IDLE, counters to 0, and clear the pending write and held values.
REQ-027 SHALL leave line-buffer contents undefined after reset; they are always written before being read within a frame.
REQ-028 SHALL process the first i_valid after reset deasserts as pixel (0,0).

Verification
REQ-029 SHALL pass: full 64x64 frame, pixel value = row*64+col on ch0 and its negation on ch1 -> 1024 ch0 writes, each equal to (2p+1)*64+(2q+1) at addr {p,q}; every ch1 write = 0; one o_done.
REQ-030 SHALL pass: block (0,0) with ch0 = 5, -3, 7, 2 -> ch0 write addr 0, data 7, one cycle after pixel (1,1); ch1 write on the next cycle.
REQ-031 SHALL pass: all inputs = 0xFFFFF (-1) -> all 2048 writes have data 0.
REQ-032 SHALL pass: same frame with random 0-5 cycle i_valid gaps -> identical write sequence to the gap-free run.
REQ-033 SHALL pass: reset asserted after 1000 pixels, then a full fresh frame -> no write during reset; the frame is exactly correct and the write count is 2048.
REQ-034 SHALL pass: two back-to-back frames -> o_done pulses twice; the second frame's first write is to addr 0.
